// File: rtl/sram_phy_seq_if.sv
// Request/response bus and SRAM pad signals for the word-to-halfword SRAM sequencer.
interface sram_phy_seq_if;
  logic        start;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic [17:0] sram_a;
  logic [15:0] sram_dq_i;
  logic [15:0] sram_dq_o;
  logic        sram_dq_oe;
  logic        sram_cs_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  modport slave (
    input  start, cmd, addr, wdata, wstrb, sram_dq_i,
    output busy, done, rdata, sram_a, sram_dq_o, sram_dq_oe,
           sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output start, cmd, addr, wdata, wstrb, sram_dq_i,
    input  busy, done, rdata, sram_a, sram_dq_o, sram_dq_oe,
           sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/sram_phy_seq.sv
// Splits each 32-bit request into two timed 16-bit cycles on an asynchronous 256Kx16 SRAM.
// All outputs are registered from the next-state decode so they line up with the state.
module sram_phy_seq #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  sram_phy_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD_LO, RD_HI,
    WR_LO_SU, WR_LO_WE, WR_LO_HD,
    WR_HI_SU, WR_HI_WE, WR_HI_HD,
    DONE
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);
  localparam logic [7:0] CMD_RD   = 8'h01;
  localparam logic [7:0] CMD_WR   = 8'h02;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        timer_end;

  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [16:0] word_eff;
  logic [31:0] wdata_eff;
  logic [3:0]  wstrb_eff;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q;
  logic [17:0] a_q, a_d;
  logic [15:0] dq_o_q, dq_o_d;
  logic        dq_oe_q, dq_oe_d;
  logic        cs_n_q, cs_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:19], bus.addr[1:0]};

  assign timer_end = (cnt_q == LAST_CNT);

  // Leaving IDLE the latches are not loaded yet, so outputs come straight from the request
  always_comb begin
    word_eff  = word_q;
    wdata_eff = wdata_q;
    wstrb_eff = wstrb_q;
    if (state_q == IDLE) begin
      word_eff  = bus.addr[18:2];
      wdata_eff = bus.wdata;
      wstrb_eff = bus.wstrb;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.cmd == CMD_RD)           state_d = RD_LO;
          else if (bus.cmd == CMD_WR) begin
            if (|bus.wstrb[1:0])           state_d = WR_LO_SU;
            else if (|bus.wstrb[3:2])      state_d = WR_HI_SU;
            else                           state_d = DONE;
          end
          else                             state_d = DONE;
        end
      end
      RD_LO:    if (timer_end) state_d = RD_HI;
      RD_HI:    if (timer_end) state_d = DONE;
      WR_LO_SU: state_d = WR_LO_WE;
      WR_LO_WE: if (timer_end) state_d = WR_LO_HD;
      WR_LO_HD: state_d = (|wstrb_q[3:2]) ? WR_HI_SU : DONE;
      WR_HI_SU: state_d = WR_HI_WE;
      WR_HI_WE: if (timer_end) state_d = WR_HI_HD;
      WR_HI_HD: state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    cnt_d = 4'd0;
    if ((state_d == state_q) &&
        (state_q == RD_LO || state_q == RD_HI || state_q == WR_LO_WE || state_q == WR_HI_WE))
      cnt_d = cnt_q + 4'd1;
  end

  // Pad controls for the state being entered; address and data hold when idle
  always_comb begin
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    a_d     = a_q;
    dq_o_d  = dq_o_q;
    dq_oe_d = 1'b0;
    cs_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    unique case (state_d)
      RD_LO, RD_HI: begin
        a_d    = {word_eff, (state_d == RD_HI)};
        cs_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
      WR_LO_SU, WR_LO_WE, WR_LO_HD: begin
        a_d     = {word_eff, 1'b0};
        dq_o_d  = wdata_eff[15:0];
        dq_oe_d = 1'b1;
        cs_n_d  = 1'b0;
        we_n_d  = (state_d != WR_LO_WE);
        ub_n_d  = ~wstrb_eff[1];
        lb_n_d  = ~wstrb_eff[0];
      end
      WR_HI_SU, WR_HI_WE, WR_HI_HD: begin
        a_d     = {word_eff, 1'b1};
        dq_o_d  = wdata_eff[31:16];
        dq_oe_d = 1'b1;
        cs_n_d  = 1'b0;
        we_n_d  = (state_d != WR_HI_WE);
        ub_n_d  = ~wstrb_eff[3];
        lb_n_d  = ~wstrb_eff[2];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 32'd0;
      a_q     <= 18'd0;
      dq_o_q  <= 16'd0;
      dq_oe_q <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      dq_o_q  <= dq_o_d;
      dq_oe_q <= dq_oe_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      // Sample the pad at the end of the final access cycle of each read half
      if (state_q == RD_LO && timer_end) rdata_q[15:0]  <= bus.sram_dq_i;
      if (state_q == RD_HI && timer_end) rdata_q[31:16] <= bus.sram_dq_i;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start) begin
      word_q  <= bus.addr[18:2];
      wdata_q <= bus.wdata;
      wstrb_q <= bus.wstrb;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.sram_a     = a_q;
  assign bus.sram_dq_o  = dq_o_q;
  assign bus.sram_dq_oe = dq_oe_q;
  assign bus.sram_cs_n  = cs_n_q;
  assign bus.sram_oe_n  = oe_n_q;
  assign bus.sram_we_n  = we_n_q;
  assign bus.sram_ub_n  = ub_n_q;
  assign bus.sram_lb_n  = lb_n_q;

endmodule
